// File: rtl/cmult_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// cmult_share_arbiter_if
// Bundles the requester side and the shared-multiplier side of
// cmult_share_arbiter into one interface.
//   Requester side : req, req_d1_i/q, req_d2_i/q   -> arbiter
//                    ack, res_valid, res_i/q, res_err, busy <- arbiter
//   Multiplier side: mult_en, mult_d1_i/q, mult_d2_i/q <- arbiter
//                    mult_out_i/q, mult_valid          -> arbiter
// Modports: slave = arbiter view, master = environment (clients + multiplier).
// ---------------------------------------------------------------------------
interface cmult_share_arbiter_if #(
  parameter int SIZE_DATA = 16,
  parameter int N_REQ     = 4
) ();
  logic [N_REQ-1:0]                 req;
  logic [N_REQ*SIZE_DATA-1:0]       req_d1_i;
  logic [N_REQ*SIZE_DATA-1:0]       req_d1_q;
  logic [N_REQ*(SIZE_DATA+1)-1:0]   req_d2_i;
  logic [N_REQ*(SIZE_DATA+1)-1:0]   req_d2_q;
  logic [N_REQ-1:0]                 ack;
  logic [N_REQ-1:0]                 res_valid;
  logic [2*SIZE_DATA-1:0]           res_i;
  logic [2*SIZE_DATA-1:0]           res_q;
  logic                             res_err;
  logic                             busy;
  logic                             mult_en;
  logic [SIZE_DATA-1:0]             mult_d1_i;
  logic [SIZE_DATA-1:0]             mult_d1_q;
  logic [SIZE_DATA:0]               mult_d2_i;
  logic [SIZE_DATA:0]               mult_d2_q;
  logic [2*SIZE_DATA-1:0]           mult_out_i;
  logic [2*SIZE_DATA-1:0]           mult_out_q;
  logic                             mult_valid;

  modport slave (
    input  req, req_d1_i, req_d1_q, req_d2_i, req_d2_q,
    input  mult_out_i, mult_out_q, mult_valid,
    output ack, res_valid, res_i, res_q, res_err, busy,
    output mult_en, mult_d1_i, mult_d1_q, mult_d2_i, mult_d2_q
  );

  modport master (
    output req, req_d1_i, req_d1_q, req_d2_i, req_d2_q,
    output mult_out_i, mult_out_q, mult_valid,
    input  ack, res_valid, res_i, res_q, res_err, busy,
    input  mult_en, mult_d1_i, mult_d1_q, mult_d2_i, mult_d2_q
  );
endinterface

// File: rtl/cmult_share_arbiter.sv
// ---------------------------------------------------------------------------
// cmult_share_arbiter
// Round-robin arbiter sharing one iterative complex multiplier among N_REQ
// requesters. Grants in IDLE, latches the winner's operands, strobes
// mult_en, waits for mult_valid (or aborts after TIMEOUT) and routes the
// result back to the owner with a one-cycle res_valid pulse.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - cmult_share_arbiter_if.slave (requester and multiplier signals)
// ---------------------------------------------------------------------------
module cmult_share_arbiter #(
  parameter int SIZE_DATA = 16,
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 15,
  parameter int HOLDOFF   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cmult_share_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 8;               // covers TIMEOUT <= 255 and HOLDOFF <= 256
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [N_REQ-1:0]       res_valid_q, res_valid_d;
  logic                   mult_en_q, mult_en_d;
  logic                   res_err_q, res_err_d;
  logic [2*SIZE_DATA-1:0] res_i_q, res_i_d, res_q_q, res_q_d;
  logic [SIZE_DATA-1:0]   mult_d1_i_q, mult_d1_i_d, mult_d1_q_q, mult_d1_q_d;
  logic [SIZE_DATA:0]     mult_d2_i_q, mult_d2_i_d, mult_d2_q_q, mult_d2_q_d;

  // Unpacked views of the per-requester operand slices.
  logic [SIZE_DATA-1:0]   op1_i [N_REQ];
  logic [SIZE_DATA-1:0]   op1_q [N_REQ];
  logic [SIZE_DATA:0]     op2_i [N_REQ];
  logic [SIZE_DATA:0]     op2_q [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      op1_i[k] = bus.req_d1_i[k*SIZE_DATA +: SIZE_DATA];
      op1_q[k] = bus.req_d1_q[k*SIZE_DATA +: SIZE_DATA];
      op2_i[k] = bus.req_d2_i[k*(SIZE_DATA+1) +: SIZE_DATA+1];
      op2_q[k] = bus.req_d2_q[k*(SIZE_DATA+1) +: SIZE_DATA+1];
    end
  end

  // Round-robin pick: scan offsets N_REQ down to 1 from last_grant so the
  // smallest offset (first set bit after last_grant) is written last and wins.
  logic [IDX_W-1:0] rr_idx, rr_pick;
  logic             rr_any;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    rr_idx  = '0;
    rr_pick = '0;
    rr_any  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = IDX_W'((int'(last_grant_q) + k) % N_REQ);
      if (bus.req[rr_idx]) begin
        rr_pick = rr_idx;
        rr_any  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    res_valid_d  = '0;
    mult_en_d    = 1'b0;
    res_err_d    = res_err_q;
    res_i_d      = res_i_q;
    res_q_d      = res_q_q;
    mult_d1_i_d  = mult_d1_i_q;
    mult_d1_q_d  = mult_d1_q_q;
    mult_d2_i_d  = mult_d2_i_q;
    mult_d2_q_d  = mult_d2_q_q;

    unique case (state_q)
      // Let a possibly still-running, unreset multiplier drain.
      S_FLUSH: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (rr_any) begin
          grant_d     = rr_pick;
          ack_d       = ONE_HOT0 << rr_pick;
          mult_en_d   = 1'b1;
          mult_d1_i_d = op1_i[rr_pick];
          mult_d1_q_d = op1_q[rr_pick];
          mult_d2_i_d = op2_i[rr_pick];
          mult_d2_q_d = op2_q[rr_pick];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // A valid result takes priority over the timeout in the same cycle.
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mult_valid) begin
          res_i_d     = bus.mult_out_i;
          res_q_d     = bus.mult_out_q;
          res_err_d   = 1'b0;
          res_valid_d = ONE_HOT0 << grant_q;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          res_i_d     = '0;
          res_q_d     = '0;
          res_err_d   = 1'b1;
          res_valid_d = ONE_HOT0 << grant_q;
          state_d     = S_DONE;
        end
      end
      // Guard cycle for the multiplier; commit the round-robin pointer.
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FLUSH;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      ack_q        <= '0;
      res_valid_q  <= '0;
      mult_en_q    <= 1'b0;
      res_err_q    <= 1'b0;
      // NOTE: result and operand registers are reset as well, because the
      // bus outputs must read zero as soon as reset is applied.
      res_i_q      <= '0;
      res_q_q      <= '0;
      mult_d1_i_q  <= '0;
      mult_d1_q_q  <= '0;
      mult_d2_i_q  <= '0;
      mult_d2_q_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      res_valid_q  <= res_valid_d;
      mult_en_q    <= mult_en_d;
      res_err_q    <= res_err_d;
      res_i_q      <= res_i_d;
      res_q_q      <= res_q_d;
      mult_d1_i_q  <= mult_d1_i_d;
      mult_d1_q_q  <= mult_d1_q_d;
      mult_d2_i_q  <= mult_d2_i_d;
      mult_d2_q_q  <= mult_d2_q_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_i     = res_i_q;
  assign bus.res_q     = res_q_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mult_en   = mult_en_q;
  assign bus.mult_d1_i = mult_d1_i_q;
  assign bus.mult_d1_q = mult_d1_q_q;
  assign bus.mult_d2_i = mult_d2_i_q;
  assign bus.mult_d2_q = mult_d2_q_q;
endmodule

// File: tb/tb_cmult_share_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cmult_share_arbiter
// Directed bench for cmult_share_arbiter with a behavioural iterative
// complex multiplier (programmable latency, optional hang, no reset).
// ---------------------------------------------------------------------------
module tb_cmult_share_arbiter;
  localparam int SD  = 16;
  localparam int SD2 = SD + 1;
  localparam int NR  = 4;
  localparam int TO  = 15;
  localparam int HO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmult_share_arbiter_if #(.SIZE_DATA(SD), .N_REQ(NR)) bus ();

  cmult_share_arbiter #(
    .SIZE_DATA(SD), .N_REQ(NR), .TIMEOUT(TO), .HOLDOFF(HO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Multiplier model: samples en at an edge, raises valid mdl_lat edges later
  // and computes the product from the operands held at that moment.
  logic   mdl_valid   = 1'b0;
  logic   stray_valid = 1'b0;
  logic   mdl_hang    = 1'b0;
  int     mdl_lat     = 6;
  int     mdl_cnt     = 0;
  logic [2*SD-1:0] mdl_i = '0;
  logic [2*SD-1:0] mdl_q = '0;
  longint a_i, a_q, b_i, b_q;

  always_comb begin
    a_i = longint'($signed(bus.mult_d1_i));
    a_q = longint'($signed(bus.mult_d1_q));
    b_i = longint'($signed(bus.mult_d2_i));
    b_q = longint'($signed(bus.mult_d2_q));
  end

  assign bus.mult_valid = mdl_valid | stray_valid;
  assign bus.mult_out_i = mdl_i;
  assign bus.mult_out_q = mdl_q;

  always @(posedge clk) begin
    mdl_valid <= 1'b0;
    if (bus.mult_en) begin
      mdl_cnt <= mdl_lat;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1 && !mdl_hang) begin
        mdl_valid <= 1'b1;
        mdl_i     <= 32'(a_i * b_i - a_q * b_q);
        mdl_q     <= 32'(a_i * b_q + a_q * b_i);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input int ai, input int aq,
                         input int bi, input int bq);
    bus.req_d1_i[k*SD +: SD]   = SD'(ai);
    bus.req_d1_q[k*SD +: SD]   = SD'(aq);
    bus.req_d2_i[k*SD2 +: SD2] = SD2'(bi);
    bus.req_d2_q[k*SD2 +: SD2] = SD2'(bq);
  endtask

  // Steps until ack shows up (bounded); optionally drops the acked request.
  task automatic wait_ack(input string tag, input logic [NR-1:0] exp_ack,
                          input bit drop, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == '0 && n < 60);
    check({tag, "_ack"}, bus.ack, exp_ack);
    check({tag, "_en"}, bus.mult_en, 1);
    if (drop) bus.req = bus.req & ~bus.ack;
  endtask

  // Steps until res_valid (bounded); n0 = cycles already spent since ack.
  task automatic wait_res(input string tag, input logic [NR-1:0] owner,
                          input int n0, input int exp_n,
                          input logic signed [63:0] exp_i,
                          input logic signed [63:0] exp_q, input logic exp_err);
    int n;
    n = n0;
    do begin
      step();
      n++;
    end while (bus.res_valid == '0 && n < 60);
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_owner"}, bus.res_valid, owner);
    check({tag, "_res_i"}, $signed(bus.res_i), exp_i);
    check({tag, "_res_q"}, $signed(bus.res_q), exp_q);
    check({tag, "_err"}, bus.res_err, exp_err);
  endtask

  int exp_i [4] = '{23, 1, -8, 16};
  int exp_q [4] = '{14, 7, 6, 12};

  initial begin
    int  n;
    bit  seen_rv;
    bus.req = '0;
    bus.req_d1_i = '0;
    bus.req_d1_q = '0;
    bus.req_d2_i = '0;
    bus.req_d2_q = '0;
    // (3+4j)(5-2j)=23+14j, (1+2j)(3+j)=1+7j, (-2)(4-3j)=-8+6j, (7-j)(2+2j)=16+12j
    set_ops(0, 3, 4, 5, -2);
    set_ops(1, 1, 2, 3, 1);
    set_ops(2, -2, 0, 4, -3);
    set_ops(3, 7, -1, 2, 2);

    // Reset state and flush length.
    step();
    step();
    check("rst_busy", bus.busy, 1);
    check("rst_ack", bus.ack, 0);
    check("rst_en", bus.mult_en, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_i", bus.res_i, 0);
    check("rst_err", bus.res_err, 0);
    check("rst_d1_i", bus.mult_d1_i, 0);
    rst = 1'b0;
    repeat (HO - 1) step();
    check("flush_busy", bus.busy, 1);
    step();
    check("idle_busy", bus.busy, 0);

    // Single request.
    bus.req = 4'b0001;
    wait_ack("single", 4'b0001, 1, n);
    check("single_ack_lat", n, 1);
    step();
    check("single_en_drop", bus.mult_en, 0);
    check("single_ack_drop", bus.ack, 0);
    wait_res("single", 4'b0001, 1, 8, 23, 14, 0);
    step();
    check("single_rv_pulse", bus.res_valid, 0);
    check("single_hold_i", $signed(bus.res_i), 23);
    check("single_idle", bus.busy, 0);

    // Simultaneous requests held through reset.
    rst = 1'b1;
    bus.req = 4'b0110;
    step();
    rst = 1'b0;
    wait_ack("simul1", 4'b0010, 1, n);
    check("simul_flush_lat", n, HO + 1);
    wait_res("simul1", 4'b0010, 0, 8, 1, 7, 0);
    wait_ack("simul2", 4'b0100, 1, n);
    wait_res("simul2", 4'b0100, 0, 8, -8, 6, 0);

    // Fairness: all requests held continuously.
    rst = 1'b1;
    bus.req = 4'b1111;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [NR-1:0] e;
      e = '0;
      e[i % 4] = 1'b1;
      wait_ack($sformatf("fair%0d", i), e, 0, n);
      if (i == 5) bus.req = '0;
      wait_res($sformatf("fair%0d", i), e, 0, 8, exp_i[i % 4], exp_q[i % 4], 0);
    end

    // Timeout, then normal service resumes.
    mdl_hang = 1'b1;
    bus.req = 4'b0100;
    wait_ack("tmo", 4'b0100, 1, n);
    wait_res("tmo", 4'b0100, 0, TO + 2, 0, 0, 1);
    mdl_hang = 1'b0;
    bus.req = 4'b0001;
    wait_ack("after_tmo", 4'b0001, 1, n);
    wait_res("after_tmo", 4'b0001, 0, 8, 23, 14, 0);

    // Valid arriving on the last allowed WAIT cycle beats the timeout.
    mdl_lat = TO;
    bus.req = 4'b1000;
    wait_ack("edge", 4'b1000, 1, n);
    wait_res("edge", 4'b1000, 0, TO + 2, 16, 12, 0);
    mdl_lat = 6;

    // Reset three cycles into WAIT.
    bus.req = 4'b0010;
    wait_ack("rstw", 4'b0010, 0, n);
    step();
    step();
    step();
    rst = 1'b1;
    bus.req = 4'b0011;
    #1;
    check("rstw_ack", bus.ack, 0);
    check("rstw_en", bus.mult_en, 0);
    check("rstw_res_valid", bus.res_valid, 0);
    check("rstw_res_i", bus.res_i, 0);
    check("rstw_res_q", bus.res_q, 0);
    check("rstw_d1_i", bus.mult_d1_i, 0);
    check("rstw_d2_q", bus.mult_d2_q, 0);
    check("rstw_busy", bus.busy, 1);
    step();
    rst = 1'b0;
    n = 0;
    seen_rv = 1'b0;
    do begin
      step();
      n++;
      if (bus.res_valid != '0) seen_rv = 1'b1;
    end while (bus.ack == '0 && n < 60);
    check("rstw_lat", n, HO + 1);
    check("rstw_first", bus.ack, 4'b0001);
    check("rstw_no_rv", seen_rv, 0);
    bus.req = 4'b0010;
    wait_res("rstw0", 4'b0001, 0, 8, 23, 14, 0);
    wait_ack("rstw1", 4'b0010, 1, n);
    wait_res("rstw1", 4'b0010, 0, 8, 1, 7, 0);

    // Stray valid in IDLE and in ISSUE.
    step();
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    check("stray_idle_rv", bus.res_valid, 0);
    check("stray_idle_busy", bus.busy, 0);
    bus.req = 4'b0100;
    wait_ack("stray", 4'b0100, 1, n);
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    check("stray_issue_rv", bus.res_valid, 0);
    wait_res("stray", 4'b0100, 1, 8, -8, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
